// File: rtl/dma_copy_master.sv
// dma_copy_master: bus initiator that copies a block of 32-bit words from a
// source to a destination address, one read followed by one write per word.
// It arbitrates with bus_req/bus_gnt and flags completion with done/irqout.
module dma_copy_master #(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic             rd,
  output logic             wr,
  output logic [31:0]      addr,
  output logic [31:0]      wdata,
  input  logic [31:0]      rdata,
  output logic             busy,
  output logic             done,
  output logic             irqout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [LEN_W-1:0] count_q;
  logic [31:0]      buf_q;
  logic             busy_q;
  logic             irq_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; READ/WRITE only advance on a granted bus cycle.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = (len == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (abort) begin
          next_state = S_DONE;
        end else if (bus_gnt) begin
          next_state = S_READ;
        end
      end
      S_READ: begin
        if (bus_gnt) begin
          next_state = abort ? S_DONE : S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus_gnt) begin
          next_state = (abort || (count_q == LEN_W'(1))) ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Bus strobes and status outputs; strobes are gated by the grant.
  always_comb begin
    bus_req = 1'b0;
    rd      = 1'b0;
    wr      = 1'b0;
    addr    = '0;
    wdata   = buf_q;
    done    = 1'b0;
    busy    = busy_q;
    irqout  = irq_q;
    case (state)
      S_REQ: begin
        bus_req = 1'b1;
      end
      S_READ: begin
        bus_req = 1'b1;
        rd      = bus_gnt;
        addr    = src_q;
      end
      S_WRITE: begin
        bus_req = 1'b1;
        wr      = bus_gnt;
        addr    = dst_q;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        bus_req = 1'b0;
      end
    endcase
  end

  // Address/count/data registers plus busy and sticky interrupt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q   <= '0;
      dst_q   <= '0;
      count_q <= '0;
      buf_q   <= '0;
      busy_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            src_q   <= src_addr & 32'hFFFF_FFFC;
            dst_q   <= dst_addr & 32'hFFFF_FFFC;
            count_q <= len;
            busy_q  <= 1'b1;
            irq_q   <= 1'b0;
          end
        end
        S_READ: begin
          if (bus_gnt) begin
            src_q <= src_q + 32'd4;
            if (!abort) begin
              buf_q <= rdata;
            end
          end
        end
        S_WRITE: begin
          if (bus_gnt) begin
            dst_q   <= dst_q + 32'd4;
            count_q <= count_q - LEN_W'(1);
          end
        end
        S_DONE: begin
          busy_q <= 1'b0;
        end
        default: begin
          busy_q <= busy_q;
        end
      endcase
      // Raise irqout on entry to DONE so it rises together with done; this
      // overrides the clear from a len==0 start that goes straight to DONE.
      if (next_state == S_DONE && state != S_DONE) begin
        irq_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dma_copy_master.sv
// Testbench for dma_copy_master: pattern-memory bus slave, transaction logs
// and a word-list reference model of the expected copy.
module tb_dma_copy_master;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic [LEN_W-1:0] len;
  logic             bus_req;
  logic             bus_gnt;
  logic             rd;
  logic             wr;
  logic [31:0]      addr;
  logic [31:0]      wdata;
  logic [31:0]      rdata;
  logic             busy;
  logic             done;
  logic             irqout;

  dma_copy_master #(.LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .rd(rd), .wr(wr),
    .addr(addr), .wdata(wdata), .rdata(rdata),
    .busy(busy), .done(done), .irqout(irqout)
  );

  always #5 clk = ~clk;

  // Source memory: every word holds a seeded hash of its address.
  logic [31:0] mem_seed;
  assign rdata = (addr * 32'h9E37_79B1) ^ mem_seed;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ mem_seed;
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rd_log[$];
  logic [31:0] wa_log[$];
  logic [31:0] wd_log[$];
  int   done_cyc, done_pulses, viol;
  logic irq_c1, busy_c1, busy_after, irq_after, req_after, done_after;

  // Run one copy; mode 0 full grant, 1 grant low cycles 5..9, 2 abort in
  // cycle 6, 3 random grant, 4 extra starts in cycle 3 and the DONE cycle.
  task run_copy(input logic [31:0] s, input logic [31:0] d, input int l, input int mode);
    int cyc;
    rd_log.delete(); wa_log.delete(); wd_log.delete();
    done_cyc = -1; done_pulses = 0; viol = 0;
    irq_c1 = 1'bx; busy_c1 = 1'bx; busy_after = 1'bx;
    irq_after = 1'bx; req_after = 1'bx; done_after = 1'bx;
    @(negedge clk);
    src_addr = s; dst_addr = d; len = LEN_W'(l);
    start = 1'b1; abort = 1'b0; bus_gnt = 1'b1;
    cyc = 0;
    while (cyc < 400) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = (mode == 4) && (cyc == 3 || cyc == 2 * l + 2);
      if (start) begin
        src_addr = 32'h0000_0500; dst_addr = 32'h0000_0600; len = LEN_W'(5);
      end
      abort = (mode == 2) && (cyc == 6);
      if (mode == 1)      bus_gnt = !(cyc >= 5 && cyc <= 9);
      else if (mode == 3) bus_gnt = ($urandom_range(3) != 0);
      else                bus_gnt = 1'b1;
      #1;
      if (rd && wr) viol++;
      if ((rd || wr) && !bus_gnt) viol++;
      if (rd && bus_gnt) rd_log.push_back(addr);
      if (wr && bus_gnt) begin
        wa_log.push_back(addr);
        wd_log.push_back(wdata);
      end
      if (cyc == 1) begin
        irq_c1 = irqout; busy_c1 = busy;
      end
      if (done) begin
        done_pulses++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        busy_after = busy; irq_after = irqout;
        req_after = bus_req; done_after = done;
        break;
      end
    end
    start = 1'b0; abort = 1'b0; bus_gnt = 1'b1;
  endtask

  task test_reset;
    int w;
    reset = 1'b0; start = 1'b0; abort = 1'b0; bus_gnt = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_checks++;
    if ({bus_req, rd, wr, busy, done, irqout} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000000", {bus_req, rd, wr, busy, done, irqout});
    end
    n_checks++;
    if (addr !== 32'h0 || wdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_bus: addr=%h wdata=%h want 0", addr, wdata);
    end
    @(negedge clk); reset = 1'b1;
    run_copy(32'h40, 32'h60, 0, 0);
    n_checks++;
    if (irq_after !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_irq: got %b want 1", irq_after);
    end
    // reset while idle clears the sticky interrupt
    @(negedge clk); reset = 1'b0; #1;
    n_checks++;
    if (irqout !== 1'b0) begin
      n_fail++; $display("FAIL reset_irq_clear: got %b want 0", irqout);
    end
    @(negedge clk); reset = 1'b1;
    // reset in the middle of a copy
    @(negedge clk);
    src_addr = 32'h1000; dst_addr = 32'h2000; len = LEN_W'(8); start = 1'b1; bus_gnt = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0; #1;
    n_checks++;
    if ({bus_req, rd, wr, busy, done, irqout} !== 6'b0 || addr !== 32'h0 || wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_midcopy: ctrl=%b addr=%h wdata=%h want all 0",
               {bus_req, rd, wr, busy, done, irqout}, addr, wdata);
    end
    w = 0;
    repeat (3) begin
      @(negedge clk); #1;
      if (wr) w++;
    end
    n_checks++;
    if (w !== 0) begin
      n_fail++; $display("FAIL reset_no_wr: writes=%0d want 0", w);
    end
    @(negedge clk); reset = 1'b1;
    run_copy(32'h3000, 32'h4000, 1, 0);
    n_checks++;
    if (done_cyc !== 4 || wa_log.size() !== 1) begin
      n_fail++; $display("FAIL reset_idle_after: done_cyc=%0d writes=%0d want 4/1", done_cyc, wa_log.size());
    end
  endtask

  task test_basic;
    run_copy(32'h10, 32'h80, 4, 0);
    n_checks++;
    if (done_cyc !== 10) begin
      n_fail++; $display("FAIL basic_done_cyc: got %0d want 10", done_cyc);
    end
    n_checks++;
    if (busy_c1 !== 1'b1 || irq_c1 !== 1'b0) begin
      n_fail++; $display("FAIL basic_start_status: busy=%b irq=%b want 1/0", busy_c1, irq_c1);
    end
    n_checks++;
    if (wa_log.size() !== 4 || rd_log.size() !== 4) begin
      n_fail++; $display("FAIL basic_count: writes=%0d reads=%0d want 4/4", wa_log.size(), rd_log.size());
    end
    for (int i = 0; i < 4 && i < wa_log.size(); i++) begin
      n_checks++;
      if (wa_log[i] !== 32'h80 + 32'(4 * i) || wd_log[i] !== pat(32'h10 + 32'(4 * i))) begin
        n_fail++;
        $display("FAIL basic_word%0d: addr=%h data=%h want %h/%h", i, wa_log[i], wd_log[i],
                 32'h80 + 32'(4 * i), pat(32'h10 + 32'(4 * i)));
      end
    end
    n_checks++;
    if (done_pulses !== 1 || done_after !== 1'b0 || irq_after !== 1'b1 || busy_after !== 1'b0 || viol !== 0) begin
      n_fail++;
      $display("FAIL basic_end: pulses=%0d done_after=%b irq=%b busy=%b viol=%0d want 1/0/1/0/0",
               done_pulses, done_after, irq_after, busy_after, viol);
    end
  endtask

  task test_len_zero;
    run_copy($urandom, $urandom, 0, 0);
    n_checks++;
    if (done_cyc !== 1) begin
      n_fail++; $display("FAIL len0_done_cyc: got %0d want 1", done_cyc);
    end
    n_checks++;
    if (rd_log.size() !== 0 || wa_log.size() !== 0) begin
      n_fail++; $display("FAIL len0_bus: reads=%0d writes=%0d want 0/0", rd_log.size(), wa_log.size());
    end
    n_checks++;
    if (irq_after !== 1'b1 || busy_after !== 1'b0) begin
      n_fail++; $display("FAIL len0_status: irq=%b busy=%b want 1/0", irq_after, busy_after);
    end
  endtask

  task test_grant_stall;
    run_copy(32'h200, 32'h300, 3, 1);
    n_checks++;
    if (done_cyc !== 13) begin
      n_fail++; $display("FAIL stall_done_cyc: got %0d want 13", done_cyc);
    end
    n_checks++;
    if (viol !== 0) begin
      n_fail++; $display("FAIL stall_strobes: violations=%0d want 0", viol);
    end
    n_checks++;
    if (wa_log.size() !== 3) begin
      n_fail++; $display("FAIL stall_count: writes=%0d want 3", wa_log.size());
    end
    for (int i = 0; i < 3 && i < wa_log.size(); i++) begin
      n_checks++;
      if (wa_log[i] !== 32'h300 + 32'(4 * i) || wd_log[i] !== pat(32'h200 + 32'(4 * i))) begin
        n_fail++;
        $display("FAIL stall_word%0d: addr=%h data=%h want %h/%h", i, wa_log[i], wd_log[i],
                 32'h300 + 32'(4 * i), pat(32'h200 + 32'(4 * i)));
      end
    end
  endtask

  task test_abort;
    run_copy(32'h400, 32'h800, 8, 2);
    n_checks++;
    if (wa_log.size() !== 2 || rd_log.size() !== 3) begin
      n_fail++; $display("FAIL abort_count: writes=%0d reads=%0d want 2/3", wa_log.size(), rd_log.size());
    end
    n_checks++;
    if (done_cyc !== 7 || done_pulses !== 1 || busy_after !== 1'b0 || irq_after !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_end: done_cyc=%0d pulses=%0d busy=%b irq=%b want 7/1/0/1",
               done_cyc, done_pulses, busy_after, irq_after);
    end
    for (int i = 0; i < 2 && i < wa_log.size(); i++) begin
      n_checks++;
      if (wa_log[i] !== 32'h800 + 32'(4 * i) || wd_log[i] !== pat(32'h400 + 32'(4 * i))) begin
        n_fail++; $display("FAIL abort_word%0d: addr=%h data=%h", i, wa_log[i], wd_log[i]);
      end
    end
  endtask

  task test_wrap_busy_start;
    run_copy(32'hFFFF_FFFE, 32'h0000_0101, 2, 4);
    n_checks++;
    if (rd_log.size() !== 2 || rd_log[0] !== 32'hFFFF_FFFC || rd_log[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_reads: n=%0d first=%h second=%h want 2/fffffffc/00000000",
               rd_log.size(), (rd_log.size() > 0) ? rd_log[0] : 32'hx, (rd_log.size() > 1) ? rd_log[1] : 32'hx);
    end
    n_checks++;
    if (wa_log.size() !== 2) begin
      n_fail++; $display("FAIL wrap_count: writes=%0d want 2", wa_log.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (wa_log[i] !== 32'h100 + 32'(4 * i) || wd_log[i] !== pat(32'hFFFF_FFFC + 32'(4 * i))) begin
          n_fail++;
          $display("FAIL wrap_word%0d: addr=%h data=%h want %h/%h", i, wa_log[i], wd_log[i],
                   32'h100 + 32'(4 * i), pat(32'hFFFF_FFFC + 32'(4 * i)));
        end
      end
    end
    n_checks++;
    if (done_cyc !== 6 || busy_after !== 1'b0 || req_after !== 1'b0) begin
      n_fail++; $display("FAIL busy_start_ignored: done_cyc=%0d busy=%b req=%b want 6/0/0",
                         done_cyc, busy_after, req_after);
    end
    @(negedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || bus_req !== 1'b0) begin
      n_fail++; $display("FAIL done_start_ignored: busy=%b req=%b want 0/0", busy, bus_req);
    end
  endtask

  task test_random;
    logic [31:0] s, d;
    int l;
    for (int k = 0; k < 6; k++) begin
      mem_seed = $urandom;
      s = $urandom;
      d = s + 32'h0010_0000 + ($urandom & 32'h3);
      l = $urandom_range(10, 1);
      run_copy(s, d, l, 3);
      n_checks++;
      if (done_cyc < 0 || wa_log.size() !== l || done_pulses !== 1 || viol !== 0) begin
        n_fail++;
        $display("FAIL rand%0d_summary: done_cyc=%0d writes=%0d pulses=%0d viol=%0d want writes=%0d",
                 k, done_cyc, wa_log.size(), done_pulses, viol, l);
      end
      for (int i = 0; i < l && i < wa_log.size(); i++) begin
        n_checks++;
        if (wa_log[i] !== (d & 32'hFFFF_FFFC) + 32'(4 * i) ||
            wd_log[i] !== pat((s & 32'hFFFF_FFFC) + 32'(4 * i))) begin
          n_fail++;
          $display("FAIL rand%0d_word%0d: addr=%h data=%h want %h/%h", k, i, wa_log[i], wd_log[i],
                   (d & 32'hFFFF_FFFC) + 32'(4 * i), pat((s & 32'hFFFF_FFFC) + 32'(4 * i)));
        end
      end
    end
  endtask

  initial begin
    mem_seed = $urandom;
    test_reset;
    test_basic;
    test_len_zero;
    test_grant_stall;
    test_abort;
    test_wrap_busy_start;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
